// File: rtl/prog_ctr.sv
// Program counter and branch-resolution stage feeding fetch/decode.
// Runs the Req/Ack program handshake and resolves branches on latched or forwarded ALU flags.
module prog_ctr #(
  parameter int unsigned     PCW        = 10,
  parameter int unsigned     TW         = 8,
  parameter logic [PCW-1:0]  START_ADDR = '0
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Req,
  input  logic           Halt,
  input  logic           Stall,
  input  logic           FlagWe,
  input  logic           ZeroIn,
  input  logic           OddIn,
  input  logic           BrEn,
  input  logic [1:0]     BrCond,
  input  logic           BrRel,
  input  logic [TW-1:0]  BrTarget,
  output logic [PCW-1:0] PC,
  output logic           Running,
  output logic           Taken,
  output logic           Ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z_SET  = 2'b01;
  localparam logic [1:0] COND_Z_CLR  = 2'b10;
  localparam logic [1:0] COND_O_SET  = 2'b11;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           z_q, z_d;
  logic           o_q, o_d;
  logic           taken_q, taken_d;
  logic           running_q, running_d;
  logic           ack_q, ack_d;

  logic           active_c;
  logic           eff_z_c, eff_o_c;
  logic           cond_ok_c;
  logic [PCW-1:0] off_sext_c;
  logic [PCW-1:0] target_c;
  logic [PCW-1:0] pc_inc_c;

  // A stalled RUN cycle is frozen; everything below keys off this.
  assign active_c = (state_q == ST_RUN) && !Stall;

  // Flag forwarding: a same-cycle flag write overrides the latched copy.
  assign eff_z_c = FlagWe ? ZeroIn : z_q;
  assign eff_o_c = FlagWe ? OddIn  : o_q;

  always_comb begin
    cond_ok_c = 1'b0;
    case (BrCond)
      COND_ALWAYS: cond_ok_c = 1'b1;
      COND_Z_SET:  cond_ok_c = eff_z_c;
      COND_Z_CLR:  cond_ok_c = !eff_z_c;
      COND_O_SET:  cond_ok_c = eff_o_c;
      default:     cond_ok_c = 1'b0;
    endcase
  end

  // Relative offsets are sign-extended, absolute targets zero-extended; sums wrap mod 2^PCW.
  assign off_sext_c = PCW'($signed(BrTarget));
  assign pc_inc_c   = pc_q + PCW'(1);

  always_comb begin
    target_c = PCW'(BrTarget);
    if (BrRel) begin
      target_c = pc_q + off_sext_c;
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Req)             state_d = ST_RUN;
      ST_RUN:  if (!Stall && Halt)  state_d = ST_DONE;
      ST_DONE:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    pc_d    = pc_q;
    z_d     = z_q;
    o_d     = o_q;
    taken_d = 1'b0;
    case (state_q)
      ST_IDLE: pc_d = START_ADDR;
      ST_RUN: begin
        if (active_c) begin
          if (FlagWe) begin
            z_d = ZeroIn;
            o_d = OddIn;
          end
          if (Halt) begin
            pc_d = pc_q;
          end else if (BrEn && cond_ok_c) begin
            pc_d    = target_c;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
          end
        end
      end
      ST_DONE: pc_d = START_ADDR;
      default: pc_d = START_ADDR;
    endcase
    running_d = (state_d == ST_RUN);
    ack_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q      <= START_ADDR;
      z_q       <= 1'b0;
      o_q       <= 1'b0;
      taken_q   <= 1'b0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      z_q       <= z_d;
      o_q       <= o_d;
      taken_q   <= taken_d;
      running_q <= running_d;
      ack_q     <= ack_d;
    end
  end

  assign PC      = pc_q;
  assign Running = running_q;
  assign Taken   = taken_q;
  assign Ack     = ack_q;

endmodule

// File: tb/tb_prog_ctr.sv
// Directed bench for prog_ctr: linear stimulus with hand-computed expectations.
module tb_prog_ctr;

  localparam int unsigned PCW = 10;
  localparam int unsigned TW  = 8;

  logic           Clk = 1'b0;
  logic           Reset, Req, Halt, Stall, FlagWe, ZeroIn, OddIn, BrEn, BrRel;
  logic [1:0]     BrCond;
  logic [TW-1:0]  BrTarget;
  logic [PCW-1:0] PC;
  logic           Running, Taken, Ack;

  int checks = 0;
  int errors = 0;

  prog_ctr #(.PCW(PCW), .TW(TW), .START_ADDR('0)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Halt(Halt), .Stall(Stall),
    .FlagWe(FlagWe), .ZeroIn(ZeroIn), .OddIn(OddIn), .BrEn(BrEn),
    .BrCond(BrCond), .BrRel(BrRel), .BrTarget(BrTarget),
    .PC(PC), .Running(Running), .Taken(Taken), .Ack(Ack)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [PCW-1:0] pc, input logic run,
                         input logic tkn, input logic ack);
    chk({tag, ".pc"},  32'(PC),      32'(pc));
    chk({tag, ".run"}, 32'(Running), 32'(run));
    chk({tag, ".tkn"}, 32'(Taken),   32'(tkn));
    chk({tag, ".ack"}, 32'(Ack),     32'(ack));
  endtask

  task automatic clr();
    Req = 0; Halt = 0; Stall = 0; FlagWe = 0; ZeroIn = 0; OddIn = 0;
    BrEn = 0; BrRel = 0; BrCond = 2'b00; BrTarget = '0;
  endtask

  task automatic br(input logic [1:0] cond, input logic rel, input logic [TW-1:0] tgt);
    BrEn = 1; BrCond = cond; BrRel = rel; BrTarget = tgt;
  endtask

  initial begin
    clr();
    Reset = 0;
    step(); step();
    chk_all("reset", 10'h000, 0, 0, 0);

    Reset = 1; Req = 1;
    step();
    chk_all("start", 10'h000, 1, 0, 0);
    Req = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_all("inc", 10'(i), 1, 0, 0);
    end

    // Forwarded Z=1 makes BrCond=01 true; 5 + (-3) = 2
    FlagWe = 1; ZeroIn = 1; br(2'b01, 1, 8'hFD);
    step(); chk_all("fwd_rel", 10'h002, 1, 1, 0);
    clr();

    br(2'b10, 0, 8'h40);
    step(); chk_all("zclr_nt", 10'h003, 1, 0, 0);
    br(2'b00, 0, 8'h40);
    step(); chk_all("abs_always", 10'h040, 1, 1, 0);

    // 0x40 + (-0x41) wraps below zero to 0x3FF
    br(2'b00, 1, 8'hBF);
    step(); chk_all("rel_wrap_dn", 10'h3FF, 1, 1, 0);
    clr();
    step(); chk_all("inc_wrap", 10'h000, 1, 0, 0);
    step(); chk_all("inc_1", 10'h001, 1, 0, 0);
    br(2'b00, 1, 8'h80);
    step(); chk_all("rel_m128", 10'h381, 1, 1, 0);
    clr();

    FlagWe = 1; ZeroIn = 1; OddIn = 1;
    step(); chk_all("flag_wr", 10'h382, 1, 0, 0);
    clr();
    br(2'b11, 0, 8'h10);
    step(); chk_all("oset_t", 10'h010, 1, 1, 0);
    // Forwarded Z=0 overrides latched Z=1
    FlagWe = 1; ZeroIn = 0; OddIn = 0; br(2'b01, 0, 8'h20);
    step(); chk_all("fwd_nt", 10'h011, 1, 0, 0);
    clr();
    br(2'b10, 0, 8'h20);
    step(); chk_all("zclr_t", 10'h020, 1, 1, 0);
    clr();

    Stall = 1; Halt = 1; FlagWe = 1; ZeroIn = 1; OddIn = 1; br(2'b00, 0, 8'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 10'h020, 1, 0, 0);
    end
    clr();
    // Flags must not have been written while stalled
    br(2'b01, 0, 8'h55);
    step(); chk_all("stall_flags", 10'h021, 1, 0, 0);
    clr();

    Halt = 1; FlagWe = 1; ZeroIn = 1; br(2'b00, 0, 8'h55);
    step(); chk_all("done", 10'h021, 0, 0, 1);
    clr();
    step(); chk_all("idle_after", 10'h000, 0, 0, 0);

    Req = 1;
    step(); chk_all("restart", 10'h000, 1, 0, 0);
    Req = 0;
    // Z=1 latched during the halt cycle survives program start
    br(2'b01, 0, 8'h07);
    step(); chk_all("flag_keep", 10'h007, 1, 1, 0);
    clr();
    Req = 1;
    step(); chk_all("req_in_run", 10'h008, 1, 0, 0);
    clr();
    br(2'b00, 0, 8'hFF);
    step(); chk_all("abs_ff", 10'h0FF, 1, 1, 0);
    br(2'b00, 1, 8'h24);
    step(); chk_all("rel_123", 10'h123, 1, 1, 0);
    clr();

    Reset = 0;
    step(); chk_all("mid_reset", 10'h000, 0, 0, 0);
    Reset = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("post_reset", 10'h000, 0, 0, 0);
    end

    // Req held high through DONE is ignored there, then restarts from IDLE
    Req = 1;
    step(); chk_all("run3", 10'h000, 1, 0, 0);
    Halt = 1;
    step(); chk_all("done3", 10'h000, 0, 0, 1);
    Halt = 0;
    step(); chk_all("idle3", 10'h000, 0, 0, 0);
    step(); chk_all("rerun3", 10'h000, 1, 0, 0);
    Req = 0;
    step(); chk_all("rerun3_inc", 10'h001, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
